// File: rtl/imem_dmem_arbiter.sv
// ---------------------------------------------------------------------------
// imem_dmem_arbiter
//
// Shares one single-port, synchronous-read unified memory between the
// instruction-fetch (IF) port and the data-memory (DM) port of an RV32 core.
// At most one memory access is issued per cycle. Each transaction completes
// with a one-cycle done pulse one cycle after it is issued. With both ports
// requesting continuously, grants alternate so neither port starves.
//
// Parameters
//   ADDR_W   byte-address width of both ports (memory word address is
//            ADDR_W-2 bits)
//   PRIO_DM  tie-break when both ports become eligible together from idle:
//            1 = DM wins, 0 = IF wins
//
// Ports
//   i_clk        rising-edge clock
//   i_rst        synchronous, active-high reset
//   i_if_req     fetch request, held with i_if_addr until o_if_done
//   i_if_addr    fetch byte address ([1:0] ignored)
//   o_if_rdata   fetched instruction word
//   o_if_done    one-cycle pulse: fetch complete, o_if_rdata valid
//   i_dm_req     data request, held with all i_dm_* until o_dm_done
//   i_dm_we      1 = store, 0 = load
//   i_dm_be      store byte lanes (ignored for loads)
//   i_dm_addr    data byte address ([1:0] ignored)
//   i_dm_wdata   store data, lane-aligned
//   o_dm_rdata   load data word
//   o_dm_done    one-cycle pulse: load or store complete
//   o_mem_en     memory access strobe
//   o_mem_we     per-byte write enable, 0000 on reads
//   o_mem_addr   memory word address
//   o_mem_wdata  memory write data
//   i_mem_rdata  memory read data, valid the cycle after o_mem_en
// ---------------------------------------------------------------------------
module imem_dmem_arbiter #(
  parameter int ADDR_W  = 8,
  parameter bit PRIO_DM = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_if_req,
  input  logic [ADDR_W-1:0] i_if_addr,
  output logic [31:0]       o_if_rdata,
  output logic              o_if_done,
  input  logic              i_dm_req,
  input  logic              i_dm_we,
  input  logic [3:0]        i_dm_be,
  input  logic [ADDR_W-1:0] i_dm_addr,
  input  logic [31:0]       i_dm_wdata,
  output logic [31:0]       o_dm_rdata,
  output logic              o_dm_done,
  output logic              o_mem_en,
  output logic [3:0]        o_mem_we,
  output logic [ADDR_W-3:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  input  logic [31:0]       i_mem_rdata
);

  // RESP_x: port x was issued last cycle, its response arrives this cycle.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESP_IF = 2'd1,
    ST_RESP_DM = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic        r_dm_store;   // the DM transaction in flight is a store
  logic [31:0] r_if_hold;
  logic [31:0] r_dm_hold;

  logic        w_if_elig;
  logic        w_dm_elig;
  logic        w_grant_if;
  logic        w_grant_dm;
  logic        w_if_done;
  logic        w_dm_done;

  // Byte-offset bits are meaningless to a word-wide memory.
  logic        w_unused_addr_lsbs;
  assign w_unused_addr_lsbs = ^{i_if_addr[1:0], i_dm_addr[1:0]};

  // Grant decision, next state, memory strobes, done pulses and read-data muxes
  always_comb begin
    w_if_elig    = 1'b0;
    w_dm_elig    = 1'b0;
    w_grant_if   = 1'b0;
    w_grant_dm   = 1'b0;
    w_if_done    = 1'b0;
    w_dm_done    = 1'b0;
    w_state_next = ST_IDLE;
    o_mem_en     = 1'b0;
    o_mem_we     = 4'b0000;
    o_mem_addr   = {(ADDR_W-2){1'b0}};
    o_mem_wdata  = 32'h0000_0000;
    o_if_rdata   = 32'h0000_0000;
    o_dm_rdata   = 32'h0000_0000;

    // A port in its own response cycle is never re-granted; nothing issues
    // while reset is held.
    w_if_elig = i_if_req && (r_state != ST_RESP_IF) && !i_rst;
    w_dm_elig = i_dm_req && (r_state != ST_RESP_DM) && !i_rst;

    // Both eligible can only happen from idle; the other states exclude one port.
    if (w_if_elig && w_dm_elig) begin
      if (PRIO_DM) begin
        w_grant_dm = 1'b1;
      end else begin
        w_grant_if = 1'b1;
      end
    end else if (w_dm_elig) begin
      w_grant_dm = 1'b1;
    end else if (w_if_elig) begin
      w_grant_if = 1'b1;
    end else begin
      w_grant_if = 1'b0;
      w_grant_dm = 1'b0;
    end

    if (w_grant_dm) begin
      w_state_next = ST_RESP_DM;
      o_mem_en     = 1'b1;
      o_mem_addr   = i_dm_addr[ADDR_W-1:2];
      o_mem_we     = i_dm_we ? i_dm_be : 4'b0000;
      o_mem_wdata  = i_dm_wdata;
    end else if (w_grant_if) begin
      w_state_next = ST_RESP_IF;
      o_mem_en     = 1'b1;
      o_mem_addr   = i_if_addr[ADDR_W-1:2];
    end else begin
      w_state_next = ST_IDLE;
    end

    // Reset in a response cycle discards that response.
    case (r_state)
      ST_RESP_IF: w_if_done = !i_rst;
      ST_RESP_DM: w_dm_done = !i_rst;
      default: begin
        w_if_done = 1'b0;
        w_dm_done = 1'b0;
      end
    endcase

    if (i_rst) begin
      o_if_rdata = 32'h0000_0000;
      o_dm_rdata = 32'h0000_0000;
    end else begin
      o_if_rdata = w_if_done ? i_mem_rdata : r_if_hold;
      // A completing store leaves the last load value on dm_rdata.
      o_dm_rdata = (w_dm_done && !r_dm_store) ? i_mem_rdata : r_dm_hold;
    end
  end

  assign o_if_done = w_if_done;
  assign o_dm_done = w_dm_done;

  // State register, store flag and read-data hold registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= ST_IDLE;
      r_dm_store <= 1'b0;
      r_if_hold  <= 32'h0000_0000;
      r_dm_hold  <= 32'h0000_0000;
    end else begin
      r_state    <= w_state_next;
      r_dm_store <= w_grant_dm && i_dm_we;
      if (w_if_done) begin
        r_if_hold <= i_mem_rdata;
      end
      if (w_dm_done && !r_dm_store) begin
        r_dm_hold <= i_mem_rdata;
      end
    end
  end

endmodule
